// File: rtl/vehicle_sensor_conditioner_pkg.sv
// Shared types and default timing for the side-road vehicle sensor conditioner
// and the traffic-light timing circuit.
package vehicle_sensor_conditioner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUALIFY = 3'd1,
    ST_REQUEST = 3'd2,
    ST_SERVING = 3'd3,
    ST_FAULT   = 3'd4
  } vsc_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_MIN_PRESENCE    = 64;
  localparam int DEF_FAULT_CYCLES    = 4096;

  // Long/short phase lengths used by the timing circuit next to this block.
  localparam int DEF_TIMER_LONG_CYCLES  = 25;
  localparam int DEF_TIMER_SHORT_CYCLES = 4;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vehicle_sensor_conditioner_if.sv
// Sensor/controller side signals of the vehicle sensor conditioner.
interface vehicle_sensor_conditioner_if;
  logic raw_sensor;
  logic service_ack;
  logic vs;
  logic presence;
  logic sensor_fault;

  modport master (
    output raw_sensor,
    output service_ack,
    input  vs,
    input  presence,
    input  sensor_fault
  );

  modport slave (
    input  raw_sensor,
    input  service_ack,
    output vs,
    output presence,
    output sensor_fault
  );
endinterface

// File: rtl/vehicle_sensor_conditioner_debouncer.sv
// Synchroniser chain plus debounce counter; stable only follows the input after
// it has differed for DEBOUNCE_CYCLES consecutive cycles.
module sensor_debouncer
  import vehicle_sensor_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        db_cnt;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (sync != stable) begin
      if (db_cnt == DB_LAST) begin
        stable <= sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Turns the bouncy loop-detector level into a latched, registered vehicle call,
// with stuck-sensor fallback to a permanent call.
module vehicle_sensor_conditioner
  import vehicle_sensor_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MIN_PRESENCE    = DEF_MIN_PRESENCE,
  parameter int FAULT_CYCLES    = DEF_FAULT_CYCLES
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  vehicle_sensor_conditioner_if.slave   bus
);

  localparam int Q_W = cnt_width(MIN_PRESENCE);
  localparam int F_W = cnt_width(FAULT_CYCLES);
  // The IDLE cycle that first saw presence counts toward qualification, so
  // the last QUALIFY cycle is the one where q_cnt would reach MIN_PRESENCE-1.
  localparam logic [Q_W-1:0] Q_DONE = Q_W'(MIN_PRESENCE - 2);
  localparam logic [F_W-1:0] F_LAST = F_W'(FAULT_CYCLES - 1);

  vsc_state_e     state;
  logic           presence;
  logic           ack_d;
  logic           ack_rise;
  logic           ack_fall;
  logic           fault_hit;
  logic           vs_q;
  logic           fault_q;
  logic [Q_W-1:0] q_cnt;
  logic [F_W-1:0] f_cnt;

  sensor_debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (i_clk),
    .rst_n  (i_reset),
    .raw    (bus.raw_sensor),
    .stable (presence)
  );

  always_comb begin
    ack_rise  = bus.service_ack & ~ack_d;
    ack_fall  = ~bus.service_ack & ack_d;
    fault_hit = (f_cnt == F_LAST) && (state inside {ST_IDLE, ST_QUALIFY, ST_REQUEST});
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ack_d <= 1'b0;
      f_cnt <= '0;
    end else begin
      ack_d <= bus.service_ack;
      if (!presence || state == ST_SERVING) begin
        f_cnt <= '0;
      end else if (f_cnt != F_LAST) begin
        f_cnt <= f_cnt + 1'b1;
      end
    end
  end

  // Call FSM; o_Vs and the fault flag are set alongside the state they belong to.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= ST_IDLE;
      q_cnt   <= '0;
      vs_q    <= 1'b0;
      fault_q <= 1'b0;
    end else if (fault_hit) begin
      state   <= ST_FAULT;
      vs_q    <= 1'b1;
      fault_q <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (presence) begin
            state <= ST_QUALIFY;
            q_cnt <= '0;
          end
        end
        ST_QUALIFY: begin
          if (!presence) begin
            state <= ST_IDLE;
          end else if (q_cnt == Q_DONE) begin
            state <= ST_REQUEST;
            vs_q  <= 1'b1;
          end else begin
            q_cnt <= q_cnt + 1'b1;
          end
        end
        ST_REQUEST: begin
          if (ack_rise) begin
            state <= ST_SERVING;
            vs_q  <= presence;
          end
        end
        ST_SERVING: begin
          if (ack_fall) begin
            state <= ST_IDLE;
            vs_q  <= 1'b0;
          end else begin
            vs_q  <= presence;
          end
        end
        ST_FAULT: begin
          if (!presence) begin
            state   <= ST_IDLE;
            vs_q    <= 1'b0;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          vs_q    <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vs           = vs_q;
  assign bus.presence     = presence;
  assign bus.sensor_fault = fault_q;

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Scoreboard bench: a flag-based behavioural model predicts each cycle's outputs,
// a monitor compares them against the conditioner.
module tb_vehicle_sensor_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int MINP = 8;
  localparam int FLT  = 32;

  typedef struct packed {
    logic vs;
    logic pres;
    logic fault;
  } exp_t;

  logic i_clk;
  logic i_reset;
  int   total;
  int   bad;
  exp_t exp_q[$];

  // Reference model state: raw samples, debounced level and call flags.
  bit m_hist[$];
  bit m_stable;
  int m_differ_run;
  bit m_call;
  bit m_serving;
  bit m_stuck;
  int m_qual_run;
  int m_stuck_run;
  bit m_ack_prev;

  vehicle_sensor_conditioner_if bus();

  vehicle_sensor_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .MIN_PRESENCE    (MINP),
    .FAULT_CYCLES    (FLT)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_output(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s t=%0t got=%0b want=%0b", name, $time, got, want);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_stable     = 1'b0;
    m_differ_run = 0;
    m_call       = 1'b0;
    m_serving    = 1'b0;
    m_stuck      = 1'b0;
    m_qual_run   = 0;
    m_stuck_run  = 0;
    m_ack_prev   = 1'b0;
  endtask

  // Advance the model over one clock edge and return the outputs seen after it.
  task automatic model_edge(input bit raw, input bit ack, output exp_t e);
    bit sync_old;
    bit pres_old;
    bit rise;
    bit fall;
    bit fault_hit;
    sync_old  = (m_hist.size() >= SYNC) ? m_hist[SYNC-1] : 1'b0;
    pres_old  = m_stable;
    rise      = ack && !m_ack_prev;
    fall      = !ack && m_ack_prev;
    fault_hit = !m_serving && !m_stuck && (m_stuck_run == FLT - 1);

    m_hist.push_front(raw);
    if (m_hist.size() > SYNC) void'(m_hist.pop_back());

    if (sync_old != m_stable) begin
      m_differ_run++;
      if (m_differ_run == DEB) begin
        m_stable     = sync_old;
        m_differ_run = 0;
      end
    end else begin
      m_differ_run = 0;
    end

    if (!pres_old || m_serving) m_stuck_run = 0;
    else if (m_stuck_run < FLT - 1) m_stuck_run++;

    if (m_stuck) begin
      m_qual_run = 0;
      if (!pres_old) m_stuck = 1'b0;
    end else if (m_serving) begin
      m_qual_run = 0;
      if (fall) m_serving = 1'b0;
    end else if (fault_hit) begin
      m_stuck    = 1'b1;
      m_call     = 1'b0;
      m_qual_run = 0;
    end else if (m_call) begin
      m_qual_run = 0;
      if (rise) begin
        m_call    = 1'b0;
        m_serving = 1'b1;
      end
    end else if (pres_old) begin
      m_qual_run++;
      if (m_qual_run == MINP) begin
        m_call     = 1'b1;
        m_qual_run = 0;
      end
    end else begin
      m_qual_run = 0;
    end
    m_ack_prev = ack;

    e.vs    = m_call || m_stuck || (m_serving && pres_old);
    e.pres  = m_stable;
    e.fault = m_stuck;
  endtask

  task automatic apply_stimulus(input bit raw, input bit ack, input bit rst_n);
    exp_t e;
    @(negedge i_clk);
    bus.raw_sensor  = raw;
    bus.service_ack = ack;
    i_reset         = rst_n;
    if (!rst_n) begin
      model_reset();
      e = '0;
    end else begin
      model_edge(raw, ack, e);
    end
    exp_q.push_back(e);
  endtask

  task automatic hold(input bit raw, input bit ack, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(raw, ack, 1'b1);
  endtask

  task automatic async_reset_check();
    @(posedge i_clk);
    #3;
    i_reset = 1'b0;
    #1;
    check_output("async_rst_vs", bus.vs, 1'b0);
    check_output("async_rst_presence", bus.presence, 1'b0);
    check_output("async_rst_fault", bus.sensor_fault, 1'b0);
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge i_clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("vs", bus.vs, e.vs);
        check_output("presence", bus.presence, e.pres);
        check_output("sensor_fault", bus.sensor_fault, e.fault);
      end
    end
  end

  initial begin : stimulus
    bit raw;
    bit ack;
    int len;
    total           = 0;
    bad             = 0;
    i_reset         = 1'b0;
    bus.raw_sensor  = 1'b0;
    bus.service_ack = 1'b0;
    model_reset();
    #1;
    check_output("reset_vs", bus.vs, 1'b0);
    check_output("reset_presence", bus.presence, 1'b0);
    check_output("reset_fault", bus.sensor_fault, 1'b0);

    apply_stimulus(1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    hold(1'b0, 1'b0, 4);

    $display("[TB] held press, latched call, service with ack");
    hold(1'b1, 1'b0, 20);
    hold(1'b0, 1'b0, 20);
    hold(1'b0, 1'b1, 5);
    hold(1'b0, 1'b0, 5);

    $display("[TB] short glitch");
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 10);

    $display("[TB] presence lost during qualification, then re-press");
    hold(1'b1, 1'b0, 5);
    hold(1'b0, 1'b0, 12);
    hold(1'b1, 1'b0, 16);
    hold(1'b0, 1'b0, 10);
    hold(1'b0, 1'b1, 3);
    hold(1'b0, 1'b0, 8);

    $display("[TB] ack in IDLE and QUALIFY, ack rise in REQUEST");
    hold(1'b0, 1'b1, 2);
    hold(1'b0, 1'b0, 2);
    hold(1'b1, 1'b0, 9);
    hold(1'b1, 1'b1, 2);
    hold(1'b1, 1'b0, 4);
    hold(1'b1, 1'b1, 4);
    hold(1'b1, 1'b0, 1);
    hold(1'b0, 1'b0, 20);
    hold(1'b0, 1'b1, 2);
    hold(1'b0, 1'b0, 4);

    $display("[TB] stuck sensor");
    hold(1'b1, 1'b0, 50);
    hold(1'b1, 1'b1, 3);
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 10);

    $display("[TB] asynchronous reset during REQUEST");
    hold(1'b1, 1'b0, 16);
    async_reset_check();
    apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    hold(1'b1, 1'b0, 16);
    hold(1'b0, 1'b0, 8);
    hold(1'b0, 1'b1, 2);
    hold(1'b0, 1'b0, 8);

    $display("[TB] randomized traffic");
    ack = 1'b0;
    for (int seg = 0; seg < 70; seg++) begin
      raw = 1'($urandom_range(0, 1));
      len = (raw && $urandom_range(0, 9) == 0) ? 45 : int'($urandom_range(1, 30));
      if ($urandom_range(0, 29) == 0) apply_stimulus(raw, ack, 1'b0);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 7) == 0) ack = ~ack;
        apply_stimulus(raw, ack, 1'b1);
      end
    end

    repeat (3) @(posedge i_clk);
    #3;
    check_output("scoreboard_drained", 1'(exp_q.size() == 0), 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
